// File: rtl/cbus_mem_responder_if.sv
// rtl/cbus_mem_responder_if.sv - CBus request/response bundle between a bus master and the memory responder.
interface cbus_mem_responder_if;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
    logic [3:0]  len;
    logic        burst;    // 0 = FIXED, 1 = INCR
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  cbus_req_t  creq;
  cbus_resp_t cresp;

  modport master (output creq, input cresp);
  modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_mem_responder.sv
// rtl/cbus_mem_responder.sv - CBus memory model: fixed-latency, single/burst reads and byte-strobed writes.
module cbus_mem_responder #(
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  cbus_mem_responder_if.slave  bus,
  output logic                 busy
);

  localparam int          IW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
  localparam logic [15:0] LAT_INIT = (LATENCY > 0) ? 16'(LATENCY - 1) : 16'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  beat_q, beat_d;
  logic [3:0]  len_q, len_d;
  logic [63:0] addr_q, addr_d;
  logic        wr_q, wr_d;
  logic        incr_q, incr_d;

  logic [63:0] mem [DEPTH_WORDS];

  logic [63:0] beat_addr;
  logic [63:0] off;
  logic        in_range;
  logic [IW-1:0] idx;
  logic        is_last;
  logic        resp_ready;
  logic        resp_last;
  logic [63:0] resp_data;
  logic        wr_en;

  always_comb begin
    beat_addr = {addr_q[63:3], 3'b000} + (incr_q ? {57'd0, beat_q, 3'b000} : 64'd0);
    off       = beat_addr - BASE_ADDR;
    in_range  = off < SPAN;
    idx       = off[IW+2:3];
    is_last   = (beat_q == len_q);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    len_d   = len_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    incr_d  = incr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.creq.valid) begin
          addr_d = bus.creq.addr;
          wr_d   = bus.creq.is_write;
          len_d  = bus.creq.len;
          incr_d = bus.creq.burst;
          beat_d = 4'd0;
          if (LATENCY == 0) begin
            state_d = S_BURST;
            cnt_d   = 16'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = LAT_INIT;
          end
        end
      end
      S_WAIT: begin
        // A dropped valid mid-transaction abandons it rather than stalling.
        if (!bus.creq.valid) begin
          state_d = S_IDLE;
          cnt_d   = 16'd0;
        end else if (cnt_q == 16'd0) begin
          state_d = S_BURST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BURST: begin
        if (!bus.creq.valid || is_last) begin
          state_d = S_IDLE;
          beat_d  = 4'd0;
          cnt_d   = 16'd0;
        end else begin
          beat_d = beat_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 16'd0;
        beat_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'd0;
      beat_q  <= 4'd0;
      len_q   <= 4'd0;
      addr_q  <= 64'd0;
      wr_q    <= 1'b0;
      incr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      incr_q  <= incr_d;
    end
  end

  // Memory is deliberately left out of reset so contents survive an aborted burst.
  assign wr_en = !reset && (state_q == S_BURST) && wr_q && bus.creq.valid && in_range;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (bus.creq.strobe[i]) begin
          mem[idx][8*i +: 8] <= bus.creq.data[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    resp_ready = (state_q == S_BURST);
    resp_last  = resp_ready && is_last;
    resp_data  = (resp_ready && !wr_q && in_range) ? mem[idx] : 64'd0;
  end

  assign bus.cresp = {resp_ready, resp_last, resp_data};
  assign busy      = (state_q != S_IDLE);

  logic unused_bits;
  assign unused_bits = ^{bus.creq.size, addr_q[2:0], off};

endmodule

// File: doc/cbus_mem_responder.md
CBUS_MEM_RESPONDER -- requirements
Module: cbus_mem_responder

Interface
- REQ-001: The module SHALL have parameter BASE_ADDR, default 64'h8000_0000, meaning the byte address of memory word 0.
- REQ-002: The module SHALL have parameter DEPTH_WORDS, default 4096 (power of two), meaning the number of 64-bit words in the backing array.
- REQ-003: The module SHALL have parameter LATENCY, default 2, meaning the number of idle wait cycles between request capture and the first data beat (0 allowed).
- REQ-004: clk  input  1  the single clock; all state changes on posedge clk.
- REQ-005: reset  input  1  synchronous, active-high reset.
- REQ-006: creq  input  cbus_req_t  the CBus request: valid, is_write, size, addr[63:0], strobe[7:0], data[63:0], len (beats-1, 0..15), burst (FIXED/INCR).
- REQ-007: cresp  output  cbus_resp_t  the CBus response: ready, last, data[63:0].
- REQ-008: busy  output  1  high whenever state is not IDLE.

Function
- REQ-009: The module SHALL implement states IDLE, WAIT and BURST.
- REQ-010: In IDLE with creq.valid=1 at a clock edge, the module SHALL latch addr, is_write, len and burst, clear beat index to 0, and enter WAIT with counter=LATENCY-1, or enter BURST directly when LATENCY=0.
- REQ-011: In WAIT, the counter SHALL decrement each cycle; at counter 0 the state SHALL become BURST on the next edge.
- REQ-012: cresp.ready SHALL be 1 exactly in BURST, one beat per cycle, with no stall cycles inside a burst.
- REQ-013: cresp.last SHALL be 1 only in BURST when beat index equals latched len.
- REQ-014: The beat address SHALL be {latched addr[63:3],3'b0} + 8*beat for INCR, and {latched addr[63:3],3'b0} for FIXED.
- REQ-015: The word index SHALL be (beat address - BASE_ADDR)>>3; the address is in range iff beat address - BASE_ADDR < 8*DEPTH_WORDS (unsigned, 64-bit).
- REQ-016: A read beat SHALL drive cresp.data = mem[index] combinationally for in-range addresses and 64'h0 for out-of-range addresses.
- REQ-017: A write beat SHALL update, at the edge ending the beat, each byte lane i of mem[index] with creq.data[8i+7:8i] where creq.strobe[i]=1, using the live creq.data/strobe of that cycle.
- REQ-018: Out-of-range writes SHALL be dropped without error indication.
- REQ-019: The beat index SHALL increment after each non-last beat; after the last beat the state SHALL return to IDLE.
- REQ-020: A request still valid in the cycle after last SHALL NOT be re-accepted in that IDLE cycle; a new request SHALL be captured no earlier than one full IDLE cycle after last.
- REQ-021: If creq.valid drops in WAIT or BURST (protocol violation), the module SHALL return to IDLE on the next edge; no write SHALL occur in the cycle valid is low.
- REQ-022: cresp.data SHALL be 64'h0 when not in a read BURST.
- REQ-023: creq.size SHALL not affect behaviour; strobe alone selects write bytes.

Reset
- REQ-024: While reset=1 at an edge, state SHALL become IDLE, counter and beat index 0; cresp.ready, cresp.last, busy and cresp.data SHALL read 0 from the next cycle.
- REQ-025: Reset asserted mid-burst SHALL abort the burst without further writes; memory contents SHALL NOT be cleared by reset.

Verification
- REQ-026: Single read, LATENCY=2: preload mem[0]=64'h1122334455667788, assert valid addr 0x80000000 len 0 -> ready=last=1 with that data exactly 3 cycles after valid rises, busy low the following cycle.
- REQ-027: INCR write 4 beats at 0x80000010, strobe 8'hFF, data 1,2,3,4 -> 4 consecutive ready cycles, last on 4th; a subsequent 4-beat read returns 1,2,3,4.
- REQ-028: Partial write strobe 8'h0F data 64'hAAAAAAAA_BBBBBBBB over word 64'h0 -> read returns 64'h00000000_BBBBBBBB.
- REQ-029: FIXED read len 3 at 0x80000008 with mem[1]=5 -> four beats all data 5; read at 0x7FFFFFF8 or at BASE_ADDR+8*DEPTH_WORDS -> data 0, write dropped.
- REQ-030: Reset asserted at beat 2 of a 4-beat write -> beats 3-4 not written, ready=0 next cycle, earlier beats retained, next request served normally.
- REQ-031: Back-to-back requests with valid held high across last, LATENCY=0 -> one ready=0 IDLE cycle between bursts, second burst first ready 2 cycles after first last.
